// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between icache line fills and
// dcache line fills/write-backs. It grants one requester at a time, runs the
// fixed-latency access and returns a one-cycle ack.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking.
// When it is undefined, dcache wins every tie.

module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned OffW    = $clog2(LINE_W / 8);
  localparam logic [7:0]  CntInit = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [7:0]          r_cnt, w_cnt_d;
  logic                r_gnt_dc, w_gnt_dc_d;
  logic                r_mem_en, w_mem_en_d;
  logic                r_mem_we, w_mem_we_d;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
  logic [LINE_W-1:0]   r_mem_wdata, w_mem_wdata_d;
  logic                r_ic_ack, w_ic_ack_d;
  logic                r_dc_ack, w_dc_ack_d;
  logic [LINE_W-1:0]   r_ic_rdata, w_ic_rdata_d;
  logic [LINE_W-1:0]   r_dc_rdata, w_dc_rdata_d;
  logic                r_busy, w_busy_d;
  logic                w_any_req;
  logic                w_pick_dc;
  logic [ADDR_W-1:0]   w_addr_aligned;

  assign w_any_req = ic_req | dc_req;

`ifdef MEM_ARB_RR_EN
  logic r_rr_dc, w_rr_dc_d;

  // Tie goes to the favoured requester; a lone requester is always taken.
  always_comb w_pick_dc = (ic_req && dc_req) ? r_rr_dc : dc_req;

  // After every grant, favour the requester that was not granted.
  always_comb begin
    w_rr_dc_d = r_rr_dc;
    if (r_state == StIdle && w_any_req) w_rr_dc_d = ~w_pick_dc;
  end

  // Round-robin pointer register; icache is favoured first after reset.
  always_ff @(posedge clk) begin
    if (reset) r_rr_dc <= 1'b0;
    else       r_rr_dc <= w_rr_dc_d;
  end
`else
  assign w_pick_dc = dc_req;
`endif

  // Address of the winning requester, forced to a line boundary.
  always_comb begin
    w_addr_aligned              = w_pick_dc ? dc_addr : ic_addr;
    w_addr_aligned[OffW-1:0]    = '0;
  end

  // Next-state and next-output logic for the IDLE -> BUSY -> RESP sequence.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_gnt_dc_d    = r_gnt_dc;
    w_mem_en_d    = 1'b0;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_ic_ack_d    = 1'b0;
    w_dc_ack_d    = 1'b0;
    w_ic_rdata_d  = r_ic_rdata;
    w_dc_rdata_d  = r_dc_rdata;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d     = StBusy;
          w_cnt_d       = CntInit;
          w_gnt_dc_d    = w_pick_dc;
          w_mem_en_d    = 1'b1;
          w_mem_we_d    = w_pick_dc & dc_we;
          w_mem_addr_d  = w_addr_aligned;
          w_mem_wdata_d = w_pick_dc ? dc_wdata : '0;
        end
      end
      StBusy: begin
        if (r_cnt == 8'd0) begin
          w_state_d = StResp;
          // Write-backs leave the rdata registers untouched.
          if (!r_mem_we) begin
            if (r_gnt_dc) w_dc_rdata_d = mem_rdata;
            else          w_ic_rdata_d = mem_rdata;
          end
          w_ic_ack_d = ~r_gnt_dc;
          w_dc_ack_d = r_gnt_dc;
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  // State and registered outputs; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_gnt_dc    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_ack    <= 1'b0;
      r_dc_ack    <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_gnt_dc    <= w_gnt_dc_d;
      r_mem_en    <= w_mem_en_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_ic_ack    <= w_ic_ack_d;
      r_dc_ack    <= w_dc_ack_d;
      r_ic_rdata  <= w_ic_rdata_d;
      r_dc_rdata  <= w_dc_rdata_d;
      r_busy      <= w_busy_d;
    end
  end

  assign ic_ack    = r_ic_ack;
  assign ic_rdata  = r_ic_rdata;
  assign dc_ack    = r_dc_ack;
  assign dc_rdata  = r_dc_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters against a transaction-level model of the
// arbiter. The model tracks when the port is free, who wins each grant and the
// cycles at which mem_en and the ack must appear.

module tb_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned LW   = 128;
  localparam int          LAT  = 5;
  localparam int          NCYC = 3000;
  localparam logic [AW-1:0] AlignMask = ~32'hF;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic          ic_ack, dc_ack, mem_en, mem_we, busy;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_ack   (ic_ack),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_ack   (dc_ack),
    .dc_rdata (dc_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Transaction-level model state.
  int            m_free, m_en, m_ack, m_zero_cyc;
  bit            m_gdc, m_we, m_rr_dc;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_cap, m_ic_rd, m_dc_rd;

  // Requester state.
  bit ic_act, dc_act, rst, pick;
  bit e_ic, e_dc, e_ic_prev, e_dc_prev;
  int pct, n_mid, n_grants;

  initial begin
    reset     = 1'b1;
    ic_req    = 1'b0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    ic_addr   = '0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_rdata = '0;
    m_free = 0; m_en = -100; m_ack = -100; m_zero_cyc = 0;
    m_gdc = 1'b0; m_we = 1'b0; m_rr_dc = 1'b0;
    m_addr = '0; m_wdata = '0; m_cap = '0; m_ic_rd = '0; m_dc_rd = '0;
    ic_act = 1'b0; dc_act = 1'b0; e_ic_prev = 1'b0; e_dc_prev = 1'b0;
    n_mid = 0; n_grants = 0;
    @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      pct = (c < 1200) ? 30 : ((c < 2000) ? 100 : 60);

      // Line returned by a read becomes visible together with its ack.
      if (c == m_ack && !m_we) begin
        if (m_gdc) m_dc_rd = m_cap;
        else       m_ic_rd = m_cap;
      end
      e_ic = (c == m_ack) && !m_gdc;
      e_dc = (c == m_ack) && m_gdc;

      check("ic_ack",   ic_ack,   e_ic);
      check("dc_ack",   dc_ack,   e_dc);
      check("busy",     busy,     (c >= m_en) && (c <= m_ack));
      check("mem_en",   mem_en,   c == m_en);
      check("ic_rdata", ic_rdata, m_ic_rd);
      check("dc_rdata", dc_rdata, m_dc_rd);
      if (c >= m_en && c < m_ack) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we",   mem_we,   m_we);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (c == m_zero_cyc) begin
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we",    mem_we,    0);
      end

      // A requester drops req on the edge where it saw its ack.
      if (e_ic_prev) ic_act = 1'b0;
      if (e_dc_prev) dc_act = 1'b0;

      rst = (c < 2) ||
            ((c == m_en + 2) && (($urandom_range(0, 15) == 0) || (n_mid == 0 && c > 800)));
      if (rst) begin
        if (c >= 2) n_mid++;
        ic_act = 1'b0;
        dc_act = 1'b0;
        ic_req = 1'b0;
        dc_req = 1'b0;
      end else begin
        if (!ic_act && $urandom_range(0, 99) < pct) begin
          ic_act  = 1'b1;
          ic_addr = $urandom();
        end else if (ic_act && !m_gdc && c >= m_en && c <= m_ack) begin
          ic_addr = $urandom();  // already latched, must have no effect
        end
        if (!dc_act && $urandom_range(0, 99) < pct) begin
          dc_act   = 1'b1;
          dc_we    = 1'($urandom_range(0, 1));
          dc_addr  = $urandom();
          dc_wdata = rand_line();
        end else if (dc_act && m_gdc && c >= m_en && c <= m_ack) begin
          dc_we    = 1'($urandom_range(0, 1));
          dc_addr  = $urandom();
          dc_wdata = rand_line();
        end
        ic_req = ic_act;
        dc_req = dc_act;
      end
      reset     = rst;
      mem_rdata = rand_line();
      if (c == m_ack - 1) m_cap = mem_rdata;

      // Model: reset aborts everything; otherwise a free port grants one requester.
      if (rst) begin
        m_free     = c + 1;
        m_en       = -100;
        m_ack      = -100;
        m_zero_cyc = c + 1;
        m_ic_rd    = '0;
        m_dc_rd    = '0;
        m_rr_dc    = 1'b0;
        e_ic       = 1'b0;
        e_dc       = 1'b0;
      end else if (c >= m_free && (ic_req || dc_req)) begin
`ifdef MEM_ARB_RR_EN
        pick    = (ic_req && dc_req) ? m_rr_dc : dc_req;
        m_rr_dc = !pick;
`else
        pick = dc_req;
`endif
        m_gdc   = pick;
        m_we    = pick && dc_we;
        m_addr  = (pick ? dc_addr : ic_addr) & AlignMask;
        m_wdata = dc_wdata;
        m_en    = c + 1;
        m_ack   = c + 1 + LAT;
        m_free  = c + LAT + 2;
        n_grants++;
      end
      e_ic_prev = e_ic;
      e_dc_prev = e_dc;
    end

    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
